// File: rtl/shift_seq_unit_pkg.sv
// Shared encodings for the sequential shifter: shift modes, directions and FSM states.
package shift_seq_unit_pkg;

    typedef enum logic [1:0] {
        MODE_LOG = 2'b00,
        MODE_ARI = 2'b01,
        MODE_ROT = 2'b10,
        MODE_RTC = 2'b11
    } mode_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_seq_unit_stage.sv
// Combinational WIDTH-bit single-position shifter built from chained 4-bit slices.
// select=0 shifts toward the MSB (shift_in_right enters bit 0); select=1 shifts toward the LSB.
module shift_stage_n #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic             shift_in_right,
    input  logic             shift_in_left,
    input  logic             select,
    output logic [WIDTH-1:0] S,
    output logic             bb_right,
    output logic             bb_left
);

    localparam int SLICES = WIDTH / 4;

    for (genvar k = 0; k < SLICES; k++) begin : g_slice
        logic       lo_in;
        logic       hi_in;
        logic [3:0] d;

        // Each slice borrows its boundary bits from its neighbours or the external fills.
        if (k == 0) begin : g_lo_edge
            assign lo_in = shift_in_right;
        end else begin : g_lo_chain
            assign lo_in = data[4*k-1];
        end

        if (k == SLICES - 1) begin : g_hi_edge
            assign hi_in = shift_in_left;
        end else begin : g_hi_chain
            assign hi_in = data[4*k+4];
        end

        assign d            = data[4*k +: 4];
        assign S[4*k +: 4]  = select ? {hi_in, d[3:1]} : {d[2:0], lo_in};
    end

    assign bb_right = data[0];
    assign bb_left  = data[WIDTH-1];

endmodule

// File: rtl/shift_seq_unit.sv
// Multi-cycle sequential shifter: one single-position shift per clock, result and
// final carry published on entry to DONE together with a one-cycle done pulse.
module shift_seq_unit
    import shift_seq_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             carry_in,
    input  logic [AMT_W-1:0] amount,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out,
    output logic             carry_out
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] work, work_nxt;
    logic [AMT_W-1:0] cnt, cnt_nxt;
    logic             dir_q, dir_nxt;
    mode_t            mode_q, mode_nxt;
    logic             carry, carry_nxt;
    logic [WIDTH-1:0] dout_nxt;
    logic             cout_nxt;
    logic             load_carry;

    logic [WIDTH-1:0] shifted;
    logic             bb_right, bb_left;
    logic             fill_lsb, fill_msb, bucket;

    always_comb begin
        fill_lsb = 1'b0;
        fill_msb = 1'b0;
        case (mode_q)
            MODE_ARI: fill_msb = work[WIDTH-1];
            MODE_ROT: begin
                fill_lsb = work[WIDTH-1];
                fill_msb = work[0];
            end
            MODE_RTC: begin
                fill_lsb = carry;
                fill_msb = carry;
            end
            default: ;
        endcase
        bucket = (dir_q == DIR_RIGHT) ? bb_right : bb_left;
    end

    shift_stage_n #(.WIDTH(WIDTH)) u_stage (
        .data          (work),
        .shift_in_right(fill_lsb),
        .shift_in_left (fill_msb),
        .select        (dir_q),
        .S             (shifted),
        .bb_right      (bb_right),
        .bb_left       (bb_left)
    );

    always_comb begin
        state_nxt  = state;
        work_nxt   = work;
        cnt_nxt    = cnt;
        dir_nxt    = dir_q;
        mode_nxt   = mode_q;
        carry_nxt  = carry;
        dout_nxt   = data_out;
        cout_nxt   = carry_out;
        load_carry = (mode_t'(mode) == MODE_RTC) ? carry_in : 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    work_nxt  = data_in;
                    cnt_nxt   = amount;
                    dir_nxt   = dir;
                    mode_nxt  = mode_t'(mode);
                    carry_nxt = load_carry;
                    if (amount == '0) begin
                        state_nxt = DONE;
                        dout_nxt  = data_in;
                        cout_nxt  = load_carry;
                    end else begin
                        state_nxt = SHIFT;
                    end
                end
            end
            SHIFT: begin
                work_nxt  = shifted;
                carry_nxt = bucket;
                cnt_nxt   = cnt - 1'b1;
                // Outputs are only written on the final step so partial results stay hidden.
                if (cnt == AMT_W'(1)) begin
                    state_nxt = DONE;
                    dout_nxt  = shifted;
                    cout_nxt  = bucket;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            work      <= '0;
            cnt       <= '0;
            dir_q     <= DIR_LEFT;
            mode_q    <= MODE_LOG;
            carry     <= 1'b0;
            data_out  <= '0;
            carry_out <= 1'b0;
        end else begin
            state     <= state_nxt;
            work      <= work_nxt;
            cnt       <= cnt_nxt;
            dir_q     <= dir_nxt;
            mode_q    <= mode_nxt;
            carry     <= carry_nxt;
            data_out  <= dout_nxt;
            carry_out <= cout_nxt;
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_shift_seq_unit.sv
// Bench for shift_seq_unit: directed vectors plus randomized operations against a
// closed-form shift/rotate model.
module tb_shift_seq_unit;

    localparam int W = 8;
    localparam int A = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         dir = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic         carry_in = 1'b0;
    logic [A-1:0] amount = '0;
    logic [W-1:0] data_in = '0;
    logic         busy, done, carry_out;
    logic [W-1:0] data_out;

    int checks = 0;
    int failures = 0;

    shift_seq_unit #(.WIDTH(W), .AMT_W(A)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .dir      (dir),
        .mode     (mode),
        .carry_in (carry_in),
        .amount   (amount),
        .data_in  (data_in),
        .busy     (busy),
        .done     (done),
        .data_out (data_out),
        .carry_out(carry_out)
    );

    always #5 clk = ~clk;

    // Closed-form result of an amt-step operation.
    function automatic void model(input logic [W-1:0] d, input logic dr, input logic [1:0] md,
                                  input logic ci, input int amt,
                                  output logic [W-1:0] r, output logic c);
        logic [63:0] v, t, ring;
        int k;
        v = {56'd0, d};
        c = 1'b0;
        if (md == 2'b11) begin
            k    = amt % (W + 1);
            ring = {55'd0, ci, d};
            if (!dr) t = (ring << k) | (ring >> (W + 1 - k));
            else     t = (ring >> k) | (ring << (W + 1 - k));
            r = t[W-1:0];
            c = t[W];
        end else if (md == 2'b10) begin
            k = amt % W;
            if (!dr) t = (v << k) | (v >> (W - k));
            else     t = (v >> k) | (v << (W - k));
            r = t[W-1:0];
            if (amt != 0) c = dr ? r[W-1] : r[0];
        end else if (!dr) begin
            t = v << amt;
            r = t[W-1:0];
            if (amt != 0 && amt <= W) c = v[W-amt];
        end else begin
            if (md == 2'b01 && d[W-1]) v = {56'hFF_FFFF_FFFF_FFFF, d};
            t = v >> amt;
            r = t[W-1:0];
            if (amt != 0) c = v[amt-1];
        end
    endfunction

    task automatic run_op(input logic [W-1:0] d, input logic dr, input logic [1:0] md,
                          input logic ci, input logic [A-1:0] amt,
                          output logic [W-1:0] r, output logic c, output int lat,
                          output logic busy_early, output logic held_ok);
        @(negedge clk);
        data_in = d; dir = dr; mode = md; carry_in = ci; amount = amt; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_early = busy;
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!done) lat = -1;
        r = data_out;
        c = carry_out;
        @(negedge clk);
        held_ok = !busy && !done && (data_out === r) && (carry_out === c);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || data_out !== 8'h00 || carry_out !== 1'b0) begin
            failures++;
            $display("FAIL reset: busy=%b done=%b data_out=%h carry_out=%b required 0 0 00 0",
                     busy, done, data_out, carry_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [W-1:0] td[7]  = '{8'hB3, 8'h86, 8'hFF, 8'hA5, 8'h80, 8'h80, 8'h3C};
        logic         tdr[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [1:0]   tm[7]  = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b11, 2'b11, 2'b00};
        logic [A-1:0] ta[7]  = '{4'd3, 4'd2, 4'd12, 4'd4, 4'd1, 4'd9, 4'd0};
        logic [W-1:0] er[7]  = '{8'h98, 8'hE1, 8'h00, 8'h5A, 8'h00, 8'h80, 8'h3C};
        logic         ec[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [W-1:0] r;
        logic         c, be, ho;
        int           lat;
        for (int i = 0; i < 7; i++) begin
            run_op(td[i], tdr[i], tm[i], 1'b0, ta[i], r, c, lat, be, ho);
            checks++;
            if (r !== er[i] || c !== ec[i]) begin
                failures++;
                $display("FAIL directed_%0d: data_out=%h carry_out=%b required %h %b",
                         i, r, c, er[i], ec[i]);
            end
            checks++;
            if (lat != int'(ta[i])) begin
                failures++;
                $display("FAIL directed_lat_%0d: latency=%0d required %0d", i, lat, ta[i]);
            end
        end
    endtask

    task automatic test_ignore_start();
        int           dones = 0;
        logic [W-1:0] seen = '0;
        @(negedge clk);
        data_in = 8'h0F; dir = 1'b0; mode = 2'b00; carry_in = 1'b0; amount = 4'd5; start = 1'b1;
        for (int n = 0; n < 14; n++) begin
            @(negedge clk);
            if (n == 0) start = 1'b0;
            if (n == 2) begin
                data_in = 8'hFF; amount = 4'd0; start = 1'b1;
            end
            if (n == 3) start = 1'b0;
            if (done) begin
                dones++;
                seen = data_out;
            end
        end
        checks++;
        if (dones != 1 || seen !== 8'hE0) begin
            failures++;
            $display("FAIL ignore_start: dones=%0d data_out=%h required 1 e0", dones, seen);
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [W-1:0] r;
        logic         c, be, ho;
        int           lat;
        @(negedge clk);
        data_in = 8'h55; dir = 1'b0; mode = 2'b00; carry_in = 1'b0; amount = 4'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_ctrl: busy=%b done=%b required 0 0", busy, done);
        end
        checks++;
        if (data_out !== 8'h00 || carry_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_data: data_out=%h carry_out=%b required 00 0", data_out, carry_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h01, 1'b0, 2'b00, 1'b0, 4'd1, r, c, lat, be, ho);
        checks++;
        if (r !== 8'h02 || c !== 1'b0 || lat != 1) begin
            failures++;
            $display("FAIL after_reset: data_out=%h carry_out=%b latency=%0d required 02 0 1", r, c, lat);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] d, r, er;
        logic         dr, ci, c, ec, be, ho;
        logic [1:0]   md;
        logic [A-1:0] amt;
        int           lat;
        for (int i = 0; i < 60; i++) begin
            d   = W'($urandom_range(0, 255));
            dr  = 1'($urandom_range(0, 1));
            md  = 2'($urandom_range(0, 3));
            ci  = 1'($urandom_range(0, 1));
            amt = A'($urandom_range(0, 15));
            model(d, dr, md, ci, int'(amt), er, ec);
            run_op(d, dr, md, ci, amt, r, c, lat, be, ho);
            checks++;
            if (r !== er || c !== ec) begin
                failures++;
                $display("FAIL random_%0d: d=%h dir=%b mode=%b cin=%b amt=%0d got %h %b required %h %b",
                         i, d, dr, md, ci, amt, r, c, er, ec);
            end
            checks++;
            if (lat != int'(amt)) begin
                failures++;
                $display("FAIL random_lat_%0d: latency=%0d required %0d", i, lat, amt);
            end
            checks++;
            if (be !== 1'b1 || ho !== 1'b1) begin
                failures++;
                $display("FAIL random_busy_hold_%0d: busy_after_accept=%b held_and_idle=%b required 1 1",
                         i, be, ho);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_mid_shift();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_seq_unit.md
Name: shift_seq_unit

Overview:
Multi-cycle sequential shifter that drives the shift-in inputs of an N-bit single-position shift stage and consumes its bit-bucket outputs. It accepts a word, a direction, a mode and a shift amount, then performs one-bit shifts per clock. It captures each bit shifted out into a carry flag and reports completion with a done pulse. It sits between the ALU control sequencer and the register file write-back path.

Parameters:
WIDTH, 8, data word width; must be a multiple of 4 and at least 4.
AMT_W, 4, width of the shift-amount field; amounts 0..2^AMT_W-1 are legal, including amounts greater than WIDTH.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous reset, active-low.
start  input  1  request; sampled only in IDLE.
dir  input  1  0 = shift left (toward MSB), 1 = shift right (toward LSB).
mode  input  2  00 logical, 01 arithmetic, 10 rotate, 11 rotate-through-carry.
carry_in  input  1  initial carry; used only in mode 11.
amount  input  AMT_W  number of one-bit shifts.
data_in  input  WIDTH  operand.
busy  output  1  high from the accept edge until the done cycle ends.
done  output  1  one-cycle completion pulse.
data_out  output  WIDTH  result; valid while done is high, held until the next accept.
carry_out  output  1  last bit shifted out (mode 11: final carry flag); valid and held like data_out.

Behaviour:
- Reset (any time, including mid-shift): state IDLE; data_out, carry_out, busy and done all 0; counter 0.
- States:
  - IDLE: on start=1, load the working register from data_in and the counter from amount, latch dir and mode, and set carry to carry_in if mode=11, else 0. Go to SHIFT if amount>0, else to DONE.
  - SHIFT: each edge performs one single-position shift and decrements the counter. On the edge where the counter reaches 0, go to DONE.
  - DONE: done=1 for exactly one cycle, busy=1, then go to IDLE (busy=0).
- Timing: if start is accepted at edge t0, done is high in the cycle after edge t0+amount. Total latency is amount+1 cycles.
- busy=1 in SHIFT and DONE. start is ignored while busy; there is no queueing.
- Per-shift fill bit (shift_in) and carry update:
  - Left shift: the bit-bucket is the MSB.
    - logical and arithmetic: fill 0.
    - rotate: fill the old MSB.
    - rotate-through-carry: fill the carry.
  - Right shift: the bit-bucket is the LSB.
    - logical: fill 0.
    - arithmetic: fill the current MSB.
    - rotate: fill the old LSB.
    - rotate-through-carry: fill the carry.
  - Every shift: carry <= bit-bucket.
- Amounts greater than WIDTH are not clamped; every step executes. Rotate-through-carry uses a (WIDTH+1)-bit ring, so amount WIDTH+1 is the identity.
- data_out and carry_out update only on entry to DONE. Intermediate values are never visible.

Decomposition:
- Shared package: mode encodings (MODE_LOG, MODE_ARI, MODE_ROT, MODE_RTC), direction constants, and the state encoding (IDLE, SHIFT, DONE).
- One sub-module, shift_stage_n: combinational WIDTH-bit single-position shifter.
  - Inputs: data, shift_in_right, shift_in_left, select.
  - Outputs: S, bb_right, bb_left.
  - Built from WIDTH/4 chained 4-bit shift slices.
  - The FSM in shift_seq_unit computes the shift_in signals and consumes the bb outputs.

Test Plan:
- Left logical, data_in=8'b1011_0011, amount=3 -> done after edge t0+3; data_out=8'b1001_1000, carry_out=1.
- Right arithmetic, data_in=8'b1000_0110, amount=2 -> data_out=8'b1110_0001, carry_out=1. Then left logical, data_in=8'hFF, amount=12 -> data_out=8'h00, carry_out=0.
- Rotate right, data_in=8'hA5, amount=4 -> data_out=8'h5A, carry_out=0.
- Rotate-through-carry left, data_in=8'h80, carry_in=0:
  - amount=1 -> data_out=8'h00, carry_out=1.
  - amount=9 -> data_out=8'h80, carry_out=0.
- amount=0, data_in=8'h3C -> done in the cycle after edge t0; data_out=8'h3C, carry_out=0. A second start pulsed during a 5-step shift is ignored, and exactly one done is seen.
- rst_n pulled low during SHIFT of a 6-step shift -> busy, done, data_out and carry_out go to 0 immediately. After release, a new start with data_in=8'h01, left logical, amount=1 -> data_out=8'h02.
